shader_sequencer: RTL and testbench

SHADER_SEQUENCER -- requirements
Module: shader_sequencer

---
 rtl/shader_pkg.sv | 5 +
 rtl/shader_sequencer.sv | 72 +++++++
 tb/tb_shader_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/shader_pkg.sv
// shader_pkg: shared sequencer state encoding and instruction width
package shader_pkg;
    localparam int INSTR_W = 8;
    typedef enum logic [1:0] {IDLE, EXEC, LOAD} state_e;
endpackage

// File: rtl/shader_sequencer.sv
// shader_sequencer: steps an external circular program store through pixel runs and uploads
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = 8,
    parameter int IDX_W     = $clog2(NUM_INSTR)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pixel_start_i,
    input  logic               blank_i,
    input  logic               prog_valid_i,
    input  logic [INSTR_W-1:0] prog_data_i,
    output logic               prog_ready_o,
    output logic               shift_o,
    output logic               load_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               exec_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               pixel_done_o,
    output logic               load_done_o,
    output logic               overrun_o
);
    state_e           state;
    logic [IDX_W-1:0] idx;
    logic             last;

    assign last = idx == IDX_W'(NUM_INSTR - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            idx          <= '0;
            pixel_done_o <= 1'b0;
            load_done_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            pixel_done_o <= 1'b0;
            load_done_o  <= 1'b0;
            if (pixel_start_i && state != IDLE) overrun_o <= 1'b1;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (pixel_start_i) state <= EXEC;
                    else if (blank_i && prog_valid_i) state <= LOAD;
                end
                EXEC: begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        state        <= IDLE;
                        pixel_done_o <= 1'b1;
                    end
                end
                LOAD: if (prog_valid_i) begin
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        state       <= IDLE;
                        load_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign exec_o       = state == EXEC;
    assign prog_ready_o = state == LOAD;
    assign load_o       = prog_ready_o & prog_valid_i;
    assign shift_o      = exec_o | load_o;
    assign instr_o      = prog_data_i;
    assign idx_o        = idx;
endmodule

// File: tb/tb_shader_sequencer.sv
// tb_shader_sequencer: directed vectors against a behavioural program store
module tb_shader_sequencer;
    localparam int N = 8;
    localparam logic [7:0] DEF [N] = '{8'h10, 8'h15, 8'h74, 8'h00, 8'h70, 8'h70, 8'h70, 8'h70};

    typedef struct {
        logic       rst_n, ps, bl, pv;
        logic [7:0] pd;
        logic [9:0] exp;
        logic [7:0] head;
    } vec_t;

    logic       clk_i = 0, rst_ni = 0, pixel_start_i = 0, blank_i = 0, prog_valid_i = 0;
    logic [7:0] prog_data_i = 0;
    logic       prog_ready_o, shift_o, load_o, exec_o, pixel_done_o, load_done_o, overrun_o;
    logic [7:0] instr_o;
    logic [2:0] idx_o;
    logic [7:0] store [N];
    int         total = 0, bad = 0;
    vec_t       tbl[$];

    always #5 clk_i = ~clk_i;

    shader_sequencer #(.NUM_INSTR(N)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pixel_start_i(pixel_start_i), .blank_i(blank_i),
        .prog_valid_i(prog_valid_i), .prog_data_i(prog_data_i), .prog_ready_o(prog_ready_o),
        .shift_o(shift_o), .load_o(load_o), .instr_o(instr_o), .exec_o(exec_o), .idx_o(idx_o),
        .pixel_done_o(pixel_done_o), .load_done_o(load_done_o), .overrun_o(overrun_o)
    );

    // head is store[0]; a plain shift rotates, a load shift appends instr_o at the tail
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) store[i] <= DEF[i];
        end else if (shift_o) begin
            for (int i = 0; i < N - 1; i++) store[i] <= store[i+1];
            store[N-1] <= load_o ? instr_o : store[0];
        end
    end

    function automatic logic [9:0] o(logic rdy, sh, ld, ex, logic [2:0] idx, logic pdo, ldo, ov);
        return {rdy, sh, ld, ex, idx, pdo, ldo, ov};
    endfunction

    function automatic vec_t v(logic r, ps, bl, pv, logic [7:0] pd, logic [9:0] e, logic [7:0] h = 8'h00);
        vec_t x;
        x.rst_n = r; x.ps = ps; x.bl = bl; x.pv = pv; x.pd = pd; x.exp = e; x.head = h;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t x, string name);
        @(negedge clk_i);
        rst_ni = x.rst_n; pixel_start_i = x.ps; blank_i = x.bl; prog_valid_i = x.pv; prog_data_i = x.pd;
        #1;
        chk({name, ".ctl"}, {prog_ready_o, shift_o, load_o, exec_o, idx_o, pixel_done_o, load_done_o, overrun_o}, x.exp);
        if (x.exp[6]) chk({name, ".head"}, store[0], x.head);
        if (x.exp[7]) chk({name, ".instr"}, instr_o, x.pd);
    endtask

    task automatic pixel_run(string name, logic [7:0] base, logic use_def, logic ov);
        apply(v(1, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, ov)), {name, ".start"});
        for (int k = 0; k < N; k++)
            apply(v(1, 0, 0, 0, 0, o(0, 1, 0, 1, 3'(k), 0, 0, ov), use_def ? DEF[k] : base + 8'(k)),
                  $sformatf("%s.ex%0d", name, k));
        apply(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 0, ov)), {name, ".done"});
    endtask

    initial begin
        tbl.push_back(v(0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < N; k++) tbl.push_back(v(1, 0, 0, 0, 0, o(0, 1, 0, 1, 3'(k), 0, 0, 0), DEF[k]));
        tbl.push_back(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 0, 0)));
        tbl.push_back(v(1, 0, 0, 1, 8'h55, o(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1, 0, 0, 1, 8'h55, o(0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1, 0, 1, 1, 8'hA0, o(0, 0, 0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 3; k++) tbl.push_back(v(1, 0, 1, 1, 8'hA0 + 8'(k), o(1, 1, 1, 0, 3'(k), 0, 0, 0)));
        for (int k = 0; k < 3; k++) tbl.push_back(v(1, 0, 0, 0, 0, o(1, 0, 0, 0, 3, 0, 0, 0)));
        for (int k = 3; k < N; k++) tbl.push_back(v(1, 0, 0, 1, 8'hA0 + 8'(k), o(1, 1, 1, 0, 3'(k), 0, 0, 0)));
        tbl.push_back(v(1, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0)));
        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));
        pixel_run("runA", 8'hA0, 0, 0);

        apply(v(1, 1, 1, 1, 8'hC0, o(0, 0, 0, 0, 0, 0, 0, 0)), "prio.both");
        for (int k = 0; k < N; k++)
            apply(v(1, 0, 1, 1, 8'hC0, o(0, 1, 0, 1, 3'(k), 0, 0, 0), 8'hA0 + 8'(k)), $sformatf("prio.ex%0d", k));
        apply(v(1, 0, 1, 1, 8'hC0, o(0, 0, 0, 0, 0, 1, 0, 0)), "prio.done");
        for (int k = 0; k < N; k++)
            apply(v(1, 0, 1, 1, 8'hC0 + 8'(k), o(1, 1, 1, 0, 3'(k), 0, 0, 0)), $sformatf("prio.ld%0d", k));
        apply(v(1, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 0, 1, 0)), "prio.ldone");

        apply(v(1, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)), "ovr.start");
        for (int k = 0; k < N; k++)
            apply(v(1, k == 4, 0, 0, 0, o(0, 1, 0, 1, 3'(k), 0, 0, k > 4), 8'hC0 + 8'(k)), $sformatf("ovr.ex%0d", k));
        apply(v(1, 1, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 0, 1)), "ovr.done_start");
        for (int k = 0; k < N; k++)
            apply(v(1, 0, 0, 0, 0, o(0, 1, 0, 1, 3'(k), 0, 0, 1), 8'hC0 + 8'(k)), $sformatf("ovr.re%0d", k));
        apply(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 1, 0, 1)), "ovr.redone");

        apply(v(1, 0, 1, 1, 8'hD0, o(0, 0, 0, 0, 0, 0, 0, 1)), "rst.enter");
        for (int k = 0; k < 6; k++)
            apply(v(1, 0, 1, 1, 8'hD0 + 8'(k), o(1, 1, 1, 0, 3'(k), 0, 0, 1)), $sformatf("rst.ld%0d", k));
        #2 rst_ni = 0;
        #1 chk("rst.async", {prog_ready_o, shift_o, load_o, exec_o, idx_o, pixel_done_o, load_done_o, overrun_o}, 0);
        apply(v(0, 0, 1, 1, 8'hD6, o(0, 0, 0, 0, 0, 0, 0, 0)), "rst.hold");
        apply(v(1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 0, 0, 0)), "rst.release");
        pixel_run("runD", 8'h00, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
